// File: rtl/lsu_lane_sequencer_pkg.sv
// Shared definitions for the LSU lane sequencer: state encoding, ldst field widths
// and the lane packet width helper.
package lsu_lane_sequencer_pkg;

  localparam int LDST_SPACE_LOG = 2;
  localparam int LDST_TYPES_LOG = 2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // Lane packet layout, MSB..LSB: {addr, reg, data, space, type}.
  function automatic int lane_pkt_width(input int addr_w, input int reg_w, input int data_w,
                                        input int space_w, input int type_w);
    return addr_w + reg_w + data_w + space_w + type_w;
  endfunction

endpackage

// File: rtl/lsu_lane_sequencer_picker.sv
// Lowest-set-bit priority encoder used to pick the next pending lane.
module lsu_lane_picker #(
  parameter int NUM_LANES = 32,
  parameter int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] mask_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o
);

  // Scan downward so the lowest set bit is the final assignment.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/lsu_lane_sequencer.sv
// Serialises one warp-wide load/store packet into per-lane memory requests.
// Optional LSU_SEQ_PERF_EN adds request and busy-cycle counters.
module lsu_lane_sequencer
  import lsu_lane_sequencer_pkg::*;
#(
  parameter int NUM_LANES = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_W     = 5,
  parameter int DATA_W    = 32,
  parameter int SPACE_W   = LDST_SPACE_LOG,
  parameter int TYPE_W    = LDST_TYPES_LOG,
  parameter int WARP_W    = 5,
  parameter int PKT_W     = lane_pkt_width(ADDR_W, REG_W, DATA_W, SPACE_W, TYPE_W)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_i,
  input  logic                          store_i,
  input  logic [WARP_W-1:0]             ldstWarp_i,
  input  logic                          ldstPacketValid_i,
  input  logic [NUM_LANES-1:0]          ldstMask_i,
  input  logic [NUM_LANES*PKT_W-1:0]    ldstLanes_i,
  output logic                          stall_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic                          mem_req_we_o,
  output logic [ADDR_W-1:0]             mem_req_addr_o,
  output logic [DATA_W-1:0]             mem_req_wdata_o,
  output logic [SPACE_W-1:0]            mem_req_space_o,
  output logic [TYPE_W-1:0]             mem_req_type_o,
  input  logic                          mem_rsp_valid_i,
  input  logic [DATA_W-1:0]             mem_rsp_data_i,
  output logic                          wb_valid_o,
  output logic [WARP_W-1:0]             wb_warp_o,
  output logic [$clog2(NUM_LANES)-1:0]  wb_lane_o,
  output logic [REG_W-1:0]              wb_reg_o,
  output logic [DATA_W-1:0]             wb_data_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [31:0]                   perf_req_o,
  output logic [31:0]                   perf_busy_o
);

  localparam int LANE_W    = $clog2(NUM_LANES);
  localparam int SPACE_LSB = TYPE_W;
  localparam int DATA_LSB  = SPACE_LSB + SPACE_W;
  localparam int REG_LSB   = DATA_LSB + DATA_W;
  localparam int ADDR_LSB  = REG_LSB + REG_W;

  logic [1:0]           state_q, state_d;
  logic [NUM_LANES-1:0] pending_q, pending_d, pending_clr;
  logic [WARP_W-1:0]    warp_q, warp_d;
  logic                 load_q, load_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [WARP_W-1:0]    wb_warp_q, wb_warp_d;
  logic [LANE_W-1:0]    wb_lane_q, wb_lane_d;
  logic [REG_W-1:0]     wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [LANE_W-1:0]    lane;
  logic                 lane_any;
  logic [PKT_W-1:0]     lane_pkt;
  logic                 accept, req_fire, rsp_in_wait;

  lsu_lane_picker #(.NUM_LANES(NUM_LANES), .IDX_W(LANE_W)) u_picker (
    .mask_i (pending_q),
    .idx_o  (lane),
    .any_o  (lane_any)
  );

  // Lane fields are read straight from the held upstream register.
  always_comb begin
    lane_pkt = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane == LANE_W'(k)) lane_pkt = ldstLanes_i[k*PKT_W +: PKT_W];
    end
  end

  assign accept = (state_q == ST_IDLE) & ldstPacketValid_i & (load_i | store_i) & (|ldstMask_i);
  assign stall_o = accept | (state_q == ST_ISSUE) | (state_q == ST_WAIT_RSP);
  assign mem_req_valid_o = (state_q == ST_ISSUE) & lane_any;
  assign mem_req_we_o    = ~load_q;
  assign mem_req_addr_o  = lane_pkt[ADDR_LSB +: ADDR_W];
  assign mem_req_wdata_o = lane_pkt[DATA_LSB +: DATA_W];
  assign mem_req_space_o = lane_pkt[SPACE_LSB +: SPACE_W];
  assign mem_req_type_o  = lane_pkt[0 +: TYPE_W];

  assign req_fire    = mem_req_valid_o & mem_req_ready_i;
  assign rsp_in_wait = (state_q == ST_WAIT_RSP) & mem_rsp_valid_i;
  assign pending_clr = pending_q & ~({{(NUM_LANES-1){1'b0}}, 1'b1} << lane);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    warp_d    = warp_q;
    load_d    = load_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pending_d = ldstMask_i;
          warp_d    = ldstWarp_i;
          load_d    = load_i;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_fire) begin
          if (load_q) begin
            state_d = ST_WAIT_RSP;
          end else begin
            pending_d = pending_clr;
            state_d   = (pending_clr == '0) ? ST_DONE : ST_ISSUE;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (mem_rsp_valid_i) begin
          pending_d = pending_clr;
          state_d   = (pending_clr == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_valid_d = rsp_in_wait;
    wb_warp_d  = wb_warp_q;
    wb_lane_d  = wb_lane_q;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    if (rsp_in_wait) begin
      wb_warp_d = warp_q;
      wb_lane_d = lane;
      wb_reg_d  = lane_pkt[REG_LSB +: REG_W];
      wb_data_d = mem_rsp_data_i;
    end
    done_d = (state_d == ST_DONE);
    err_d  = err_q | (mem_rsp_valid_i & (state_q != ST_WAIT_RSP));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      warp_q     <= '0;
      load_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_warp_q  <= '0;
      wb_lane_q  <= '0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      warp_q     <= warp_d;
      load_q     <= load_d;
      wb_valid_q <= wb_valid_d;
      wb_warp_q  <= wb_warp_d;
      wb_lane_q  <= wb_lane_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_warp_o  = wb_warp_q;
  assign wb_lane_o  = wb_lane_q;
  assign wb_reg_o   = wb_reg_q;
  assign wb_data_o  = wb_data_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

`ifdef LSU_SEQ_PERF_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  always_comb begin
    perf_req_d  = perf_req_q + {31'd0, req_fire};
    perf_busy_d = perf_busy_q + {31'd0, stall_o};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_req_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      perf_req_q  <= perf_req_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_req_o  = perf_req_q;
  assign perf_busy_o = perf_busy_q;
`else
  assign perf_req_o  = '0;
  assign perf_busy_o = '0;
`endif

endmodule

// File: tb/tb_lsu_lane_sequencer.sv
// Directed bench for lsu_lane_sequencer: stores, loads, ready back-pressure,
// rejected packets, reset during a load and the optional perf counters.
module tb_lsu_lane_sequencer;
  import lsu_lane_sequencer_pkg::*;

  localparam int NL   = 32;
  localparam int AW   = 32;
  localparam int RW   = 5;
  localparam int DW   = 32;
  localparam int SW   = 2;
  localparam int TW   = 2;
  localparam int WW   = 5;
  localparam int LW   = 5;
  localparam int PW   = AW + RW + DW + SW + TW;
  localparam int RQ_W = 1 + AW + SW + TW + DW;
  localparam int WB_W = WW + LW + RW + DW;

`ifdef LSU_SEQ_PERF_EN
  localparam logic [31:0] EXP_PERF_REQ  = 32'd4;
  localparam logic [31:0] EXP_PERF_BUSY = 32'd7;
`else
  localparam logic [31:0] EXP_PERF_REQ  = 32'd0;
  localparam logic [31:0] EXP_PERF_BUSY = 32'd0;
`endif

  logic              clk, reset;
  logic              load, store, pkt_valid;
  logic [WW-1:0]     warp_in;
  logic [NL-1:0]     mask_in;
  logic [NL*PW-1:0]  lanes;
  logic              stall_o, mem_req_valid_o, mem_ready, mem_req_we_o;
  logic [AW-1:0]     mem_req_addr_o;
  logic [DW-1:0]     mem_req_wdata_o;
  logic [SW-1:0]     mem_req_space_o;
  logic [TW-1:0]     mem_req_type_o;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              wb_valid_o;
  logic [WW-1:0]     wb_warp_o;
  logic [LW-1:0]     wb_lane_o;
  logic [RW-1:0]     wb_reg_o;
  logic [DW-1:0]     wb_data_o;
  logic              done_o, err_o;
  logic [31:0]       perf_req_o, perf_busy_o;

  int checks, errors, done_cnt, stall_cnt, req_cnt, hold_cnt;
  logic [WB_W-1:0] exp_q[$];
  logic [RQ_W-1:0] req_exp_q[$];
  logic [DW-1:0]   rsp_data_q[$];

  lsu_lane_sequencer dut (
    .clk(clk), .reset(reset), .load_i(load), .store_i(store), .ldstWarp_i(warp_in),
    .ldstPacketValid_i(pkt_valid), .ldstMask_i(mask_in), .ldstLanes_i(lanes),
    .stall_o(stall_o), .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_ready),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_space_o(mem_req_space_o),
    .mem_req_type_o(mem_req_type_o), .mem_rsp_valid_i(rsp_valid), .mem_rsp_data_i(rsp_data),
    .wb_valid_o(wb_valid_o), .wb_warp_o(wb_warp_o), .wb_lane_o(wb_lane_o),
    .wb_reg_o(wb_reg_o), .wb_data_o(wb_data_o), .done_o(done_o), .err_o(err_o),
    .perf_req_o(perf_req_o), .perf_busy_o(perf_busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RQ_W-1:0] cur_req();
    return {mem_req_we_o, mem_req_addr_o, mem_req_space_o, mem_req_type_o, mem_req_wdata_o};
  endfunction

  function automatic logic [WB_W-1:0] cur_wb();
    return {wb_warp_o, wb_lane_o, wb_reg_o, wb_data_o};
  endfunction

  // scoreboard: accepted requests and writebacks, plus stall/done counters
  always @(negedge clk) begin
    if (!reset) begin
      if (stall_o) stall_cnt++;
      if (done_o) done_cnt++;
      if (mem_req_valid_o && mem_ready) begin
        req_cnt++;
        if (req_exp_q.size() == 0) check("req_unexpected", 1, 0);
        else check("req", cur_req(), req_exp_q.pop_front());
      end
      if (wb_valid_o) begin
        if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
        else check("wb", cur_wb(), exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_lanes();
    logic [AW-1:0] a;
    logic [RW-1:0] r;
    for (int k = 0; k < NL; k++) begin
      a = 32'h1000_0000 + 32'(k * 16);
      r = (k == 31) ? 5'd7 : RW'(k);
      lanes[k*PW +: PW] = {a, r, 32'h5A00_0000 + 32'(k), SW'(k % 4), TW'((k + 1) % 4)};
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pkt_valid = 1'b0; load = 1'b0; store = 1'b0; warp_in = '0; mask_in = '0;
    mem_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic run_packet(input logic ld, input logic [WW-1:0] warp, input logic [NL-1:0] mask,
                            input int lat, input int low);
    int cyc, cnt, low_left;
    bit fire, fin;
    done_cnt = 0; stall_cnt = 0; req_cnt = 0; hold_cnt = 0;
    cnt = 0; low_left = low; fin = 0; cyc = 0;
    pkt_valid = 1'b1; load = ld; store = ~ld; warp_in = warp; mask_in = mask;
    rsp_valid = 1'b0;
    while (!fin && cyc < 200) begin
      #1;
      if (mem_req_valid_o && low_left > 0) begin
        mem_ready = 1'b0;
        low_left--;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (mem_req_valid_o && !mem_ready) begin
        hold_cnt++;
        if (req_exp_q.size() == 0) check("req_hold_unexpected", 1, 0);
        else check("req_hold", cur_req(), req_exp_q[0]);
      end
      fire = mem_req_valid_o && mem_ready && !mem_req_we_o;
      step();
      cyc++;
      rsp_valid = 1'b0;
      if (fire) cnt = lat;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data = (rsp_data_q.size() > 0) ? rsp_data_q.pop_front() : '0;
        end
      end
      if (done_o) begin
        fin = 1;
        pkt_valid = 1'b0; load = 1'b0; store = 1'b0;
      end
    end
    if (!fin) check("packet_timeout", 0, 1);
    pkt_valid = 1'b0; rsp_valid = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    done_cnt = 0; stall_cnt = 0; req_cnt = 0; hold_cnt = 0;
    lanes = '0;
    fill_lanes();
    do_reset();

    check("rst_state", dut.state_q, ST_IDLE);
    check("rst_stall", stall_o, 0);
    check("rst_req_valid", mem_req_valid_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_perf_req", perf_req_o, 0);
    check("rst_perf_busy", perf_busy_o, 0);

    // store, lanes 0 and 2, ready always high
    req_exp_q.push_back({1'b1, 32'h1000_0000, 2'd0, 2'd1, 32'h5A00_0000});
    req_exp_q.push_back({1'b1, 32'h1000_0020, 2'd2, 2'd3, 32'h5A00_0002});
    run_packet(1'b0, 5'd2, 32'h0000_0005, 1, 0);
    check("st_stall_cycles", stall_cnt, 3);
    check("st_done_pulses", done_cnt, 1);
    check("st_req_count", req_cnt, 2);
    check("st_idle_after", dut.state_q, ST_IDLE);

    // load, lanes 0 and 31, two-cycle response latency
    req_exp_q.push_back({1'b0, 32'h1000_0000, 2'd0, 2'd1, 32'h5A00_0000});
    req_exp_q.push_back({1'b0, 32'h1000_01F0, 2'd3, 2'd0, 32'h5A00_001F});
    rsp_data_q.push_back(32'h1234_5678);
    rsp_data_q.push_back(32'hCAFE_F00D);
    exp_q.push_back({5'd9, 5'd0, 5'd0, 32'h1234_5678});
    exp_q.push_back({5'd9, 5'd31, 5'd7, 32'hCAFE_F00D});
    run_packet(1'b1, 5'd9, 32'h8000_0001, 2, 0);
    check("ld_stall_cycles", stall_cnt, 7);
    check("ld_done_pulses", done_cnt, 1);
    check("ld_req_count", req_cnt, 2);

    // load, lane 3, ready held low for 5 cycles
    req_exp_q.push_back({1'b0, 32'h1000_0030, 2'd3, 2'd0, 32'h5A00_0003});
    rsp_data_q.push_back(32'h0BAD_BEEF);
    exp_q.push_back({5'd3, 5'd3, 5'd3, 32'h0BAD_BEEF});
    run_packet(1'b1, 5'd3, 32'h0000_0008, 1, 5);
    check("bp_hold_cycles", hold_cnt, 5);
    check("bp_stall_cycles", stall_cnt, 8);
    check("bp_done_pulses", done_cnt, 1);

    // packets that must pass through: zero mask, then no op
    done_cnt = 0; stall_cnt = 0; req_cnt = 0;
    pkt_valid = 1'b1; store = 1'b1; load = 1'b0; mask_in = '0; warp_in = 5'd4;
    #1;
    check("zm_stall_comb", stall_o, 0);
    repeat (4) step();
    store = 1'b0; mask_in = 32'h0000_0001;
    #1;
    check("noop_stall_comb", stall_o, 0);
    repeat (4) step();
    pkt_valid = 1'b0;
    check("pass_stall_cycles", stall_cnt, 0);
    check("pass_req_count", req_cnt, 0);
    check("pass_done_pulses", done_cnt, 0);
    check("pass_state", dut.state_q, ST_IDLE);

    // reset while waiting for a load response, then a stray response
    req_exp_q.push_back({1'b0, 32'h1000_0010, 2'd1, 2'd2, 32'h5A00_0001});
    pkt_valid = 1'b1; load = 1'b1; store = 1'b0; mask_in = 32'h0000_0002; warp_in = 5'd6;
    mem_ready = 1'b1;
    step();
    check("rw_req_valid", mem_req_valid_o, 1);
    step();
    check("rw_in_wait", dut.state_q, ST_WAIT_RSP);
    check("rw_wait_stall", stall_o, 1);
    reset = 1'b1; pkt_valid = 1'b0; load = 1'b0; mem_ready = 1'b0;
    step();
    reset = 1'b0;
    check("rw_state_idle", dut.state_q, ST_IDLE);
    check("rw_err_clear", err_o, 0);
    check("rw_stall_low", stall_o, 0);
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_0001;
    step();
    rsp_valid = 1'b0;
    check("rw_no_wb", wb_valid_o, 0);
    check("rw_err_set", err_o, 1);
    step();
    check("rw_err_sticky", err_o, 1);

    // performance counters: 4 stores, ready low on 2 cycles
    do_reset();
    check("perf_err_reset", err_o, 0);
    req_exp_q.push_back({1'b1, 32'h1000_0000, 2'd0, 2'd1, 32'h5A00_0000});
    req_exp_q.push_back({1'b1, 32'h1000_0010, 2'd1, 2'd2, 32'h5A00_0001});
    req_exp_q.push_back({1'b1, 32'h1000_0020, 2'd2, 2'd3, 32'h5A00_0002});
    req_exp_q.push_back({1'b1, 32'h1000_0030, 2'd3, 2'd0, 32'h5A00_0003});
    run_packet(1'b0, 5'd1, 32'h0000_000F, 1, 2);
    check("perf_stall_cycles", stall_cnt, 7);
    check("perf_req", perf_req_o, EXP_PERF_REQ);
    check("perf_busy", perf_busy_o, EXP_PERF_BUSY);

    check("req_queue_empty", req_exp_q.size(), 0);
    check("wb_queue_empty", exp_q.size(), 0);

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
